data_memory_port: RTL and testbench

Parametrised, handshaked data-memory port between the core's load/store unit and a word-organised data RAM with variable latency. It accepts one load or store at a time. It range-checks the address, generates byte enables and shifted write data, and optionally splits misaligned accesses into two word beats. On completion it returns one response with the loaded value shifted and sign- or zero-extended.

---
 rtl/data_memory_port.sv | 258 +++++++++++++++++++++++++
 tb/tb_data_memory_port.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_port.sv
// Purpose: load/store port between the LSU and a word-organised, variable-latency data RAM.
// Latency: zero-wait-state RAM gives aligned store 2 cycles, aligned load 3 cycles, error 1 cycle.
// Backpressure: one access in flight; req_ready only in IDLE, mem_* held stable until mem_ready.
//
// Ports:
//   clock, reset             : single clock, asynchronous active-high reset
//   req_valid/req_ready      : request handshake; req_write, req_format, req_address, req_wdata
//   resp_valid/rdata/error   : one-cycle completion pulse with extended load data or error flag
//   mem_valid/mem_ready      : RAM command handshake; mem_write, mem_address, mem_byteena, mem_wdata
//   mem_rvalid/mem_rdata     : RAM read data return, one pulse per accepted read
//
// Build option: define DMEM_MISALIGNED_SPLIT_EN to split word-crossing accesses into two
// beats; without it such accesses complete with resp_error and never reach the RAM.
module data_memory_port #(
  parameter int unsigned WORD_ADDR_WIDTH = 15,
  parameter logic [31:0] DATA_BEGIN      = 32'h1001_0000,
  parameter logic [31:0] DATA_END        = 32'h1001_FFFF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [2:0]                 req_format,
  input  logic [31:0]                req_address,
  input  logic [31:0]                req_wdata,
  output logic                       resp_valid,
  output logic [31:0]                resp_rdata,
  output logic                       resp_error,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic                       mem_write,
  output logic [WORD_ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]                 mem_byteena,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_rvalid,
  input  logic [31:0]                mem_rdata
);

  // Only the byte-address bits that map onto the RAM are kept after acceptance;
  // the full address is range-checked before it is captured.
  localparam int unsigned AW = WORD_ADDR_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD0,
    S_WAIT0,
`ifdef DMEM_MISALIGNED_SPLIT_EN
    S_CMD1,
    S_WAIT1,
`endif
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic           wr_q, wr_d;
  logic [2:0]     fmt_q, fmt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           err_q, err_d;
  logic [31:0]    lo_q, lo_d;
  logic [31:0]    hi_q, hi_d;

  // Unshifted lane pattern for an access size; illegal size yields no lanes.
  function automatic logic [3:0] size_lanes(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // ---------------- classification of the incoming request ----------------
  logic [1:0]  req_size_m1;
  logic [32:0] req_last;
  logic        req_err;
`ifndef DMEM_MISALIGNED_SPLIT_EN
  logic [2:0]  req_end_lane;
`endif

  always_comb begin
    case (req_format[1:0])
      2'b01:   req_size_m1 = 2'd1;
      2'b10:   req_size_m1 = 2'd3;
      default: req_size_m1 = 2'd0;
    endcase
    // 33-bit sum so a request near 2^32 cannot wrap past the range check.
    req_last = {1'b0, req_address} + {31'b0, req_size_m1};
    req_err  = (req_format[1:0] == 2'b11) ||
               (req_address < DATA_BEGIN) ||
               (req_address > DATA_END) ||
               (req_last > {1'b0, DATA_END});
`ifndef DMEM_MISALIGNED_SPLIT_EN
    // Last byte lane past lane 3 means the access would need a second beat.
    req_end_lane = {1'b0, req_address[1:0]} + {1'b0, req_size_m1};
    if (req_end_lane > 3'd3) req_err = 1'b1;
`endif
  end

  // ---------------- lane mapping of the captured request ----------------
  logic [1:0]                 off;
  logic [4:0]                 sh;
  logic [3:0]                 mask_lo;
  logic [31:0]                wdata_lo;
  logic [WORD_ADDR_WIDTH-1:0] word0;
  logic [31:0]                p;
  logic [31:0]                ext;
`ifdef DMEM_MISALIGNED_SPLIT_EN
  logic [7:0]                 mask8;
  logic [3:0]                 mask_hi;
  logic [31:0]                wdata_hi;
  logic [WORD_ADDR_WIDTH-1:0] word1;
  logic                       need1;
`endif

  always_comb begin
    off      = addr_q[1:0];
    sh       = {off, 3'b000};
    word0    = addr_q[AW-1:2];
    wdata_lo = wdata_q << sh;
`ifdef DMEM_MISALIGNED_SPLIT_EN
    mask8    = {4'b0000, size_lanes(fmt_q[1:0])} << off;
    mask_lo  = mask8[3:0];
    mask_hi  = mask8[7:4];
    // Shift by 32 (offset 0) yields zero, which is the empty upper half.
    wdata_hi = wdata_q >> (6'd32 - {1'b0, sh});
    word1    = word0 + {{(WORD_ADDR_WIDTH-1){1'b0}}, 1'b1};
    need1    = (mask_hi != 4'b0000);
`else
    mask_lo  = size_lanes(fmt_q[1:0]) << off;
`endif
    // Low 32 bits of {hi,lo} >> 8*off.
    p = (lo_q >> sh) | (hi_q << (6'd32 - {1'b0, sh}));
    case (fmt_q[1:0])
      2'b00:   ext = {{24{~fmt_q[2] & p[7]}}, p[7:0]};
      2'b01:   ext = {{16{~fmt_q[2] & p[15]}}, p[15:0]};
      default: ext = p;
    endcase
  end

  // ---------------- state machine ----------------
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    fmt_d       = fmt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = 32'h0;
    resp_error  = 1'b0;
    mem_valid   = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_byteena = 4'b0000;
    mem_wdata   = 32'h0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d    = req_write;
          fmt_d   = req_format;
          addr_d  = req_address[AW-1:0];
          wdata_d = req_wdata;
          err_d   = req_err;
          lo_d    = 32'h0;
          hi_d    = 32'h0;
          state_d = req_err ? S_RESP : S_CMD0;
        end
      end

      S_CMD0: begin
        mem_valid   = 1'b1;
        mem_write   = wr_q;
        mem_address = word0;
        mem_byteena = mask_lo;
        mem_wdata   = wdata_lo;
        if (mem_ready) begin
          if (!wr_q) begin
            state_d = S_WAIT0;
          end else begin
`ifdef DMEM_MISALIGNED_SPLIT_EN
            state_d = need1 ? S_CMD1 : S_RESP;
`else
            state_d = S_RESP;
`endif
          end
        end
      end

      S_WAIT0: begin
        if (mem_rvalid) begin
          lo_d = mem_rdata;
`ifdef DMEM_MISALIGNED_SPLIT_EN
          state_d = need1 ? S_CMD1 : S_RESP;
`else
          state_d = S_RESP;
`endif
        end
      end

`ifdef DMEM_MISALIGNED_SPLIT_EN
      S_CMD1: begin
        mem_valid   = 1'b1;
        mem_write   = wr_q;
        mem_address = word1;
        mem_byteena = mask_hi;
        mem_wdata   = wdata_hi;
        if (mem_ready) state_d = wr_q ? S_RESP : S_WAIT1;
      end

      S_WAIT1: begin
        if (mem_rvalid) begin
          hi_d    = mem_rdata;
          state_d = S_RESP;
        end
      end
`endif

      S_RESP: begin
        resp_valid = 1'b1;
        resp_error = err_q;
        resp_rdata = (err_q || wr_q) ? 32'h0 : ext;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      fmt_q   <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      lo_q    <= 32'h0;
      hi_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      fmt_q   <= fmt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_data_memory_port.sv
module tb_data_memory_port;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_format;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_write;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  data_memory_port dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_format  (req_format),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_byteena (mem_byteena),
    .mem_wdata   (mem_wdata),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic wr, input logic [2:0] fmt, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid   = 1'b1;
    req_write   = wr;
    req_format  = fmt;
    req_address = a;
    req_wdata   = wd;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    step();
    req_valid   = 1'b0;
    req_write   = ~wr;
    req_format  = 3'b011;
    req_address = 32'hFFFF_FFFF;
    req_wdata   = 32'h5555_5555;
  endtask

  task automatic load_tx(input string tag, input logic [31:0] a, input logic [2:0] fmt,
                         input logic [31:0] word, input logic [3:0] exp_be,
                         input logic [14:0] exp_wa, input logic [31:0] exp_rd);
    issue(1'b0, fmt, a, 32'h0);
    chk({tag, ".mem_valid"}, {31'b0, mem_valid}, 32'd1);
    chk({tag, ".mem_write"}, {31'b0, mem_write}, 32'd0);
    chk({tag, ".byteena"}, {28'b0, mem_byteena}, {28'b0, exp_be});
    chk({tag, ".address"}, {17'b0, mem_address}, {17'b0, exp_wa});
    step();
    chk({tag, ".wait_no_cmd"}, {31'b0, mem_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hDEAD_0000;
    chk({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, ".resp_error"}, {31'b0, resp_error}, 32'd0);
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    step();
    chk({tag, ".resp_done"}, {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic store_tx(input string tag, input logic [31:0] a, input logic [2:0] fmt,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [14:0] exp_wa, input logic [31:0] exp_wd);
    issue(1'b1, fmt, a, wd);
    chk({tag, ".mem_valid"}, {31'b0, mem_valid}, 32'd1);
    chk({tag, ".mem_write"}, {31'b0, mem_write}, 32'd1);
    chk({tag, ".byteena"}, {28'b0, mem_byteena}, {28'b0, exp_be});
    chk({tag, ".address"}, {17'b0, mem_address}, {17'b0, exp_wa});
    chk({tag, ".wdata"}, mem_wdata, exp_wd);
    chk({tag, ".early_resp"}, {31'b0, resp_valid}, 32'd0);
    step();
    chk({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, ".resp_error"}, {31'b0, resp_error}, 32'd0);
    chk({tag, ".rdata"}, resp_rdata, 32'h0);
    step();
    chk({tag, ".resp_done"}, {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic err_tx(input string tag, input logic wr, input logic [2:0] fmt,
                        input logic [31:0] a);
    issue(wr, fmt, a, 32'hFFFF_FFFF);
    chk({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, ".resp_error"}, {31'b0, resp_error}, 32'd1);
    chk({tag, ".rdata"}, resp_rdata, 32'h0);
    chk({tag, ".no_cmd"}, {31'b0, mem_valid}, 32'd0);
    step();
    chk({tag, ".resp_done"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, ".no_cmd2"}, {31'b0, mem_valid}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, ".mem_valid"}, {31'b0, mem_valid}, 32'd0);
    chk({tag, ".mem_write"}, {31'b0, mem_write}, 32'd0);
    chk({tag, ".mem_address"}, {17'b0, mem_address}, 32'd0);
    chk({tag, ".mem_byteena"}, {28'b0, mem_byteena}, 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, ".resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, ".resp_error"}, {31'b0, resp_error}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_format  = 3'b000;
    req_address = 32'h0;
    req_wdata   = 32'h0;
    mem_ready   = 1'b1;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    step();
    step();
    chk_reset_vals("reset");
    reset = 1'b0;
    step();

    // Aligned word store, zero wait states.
    store_tx("st_word", 32'h1001_0000, 3'b010, 32'hDEAD_BEEF, 4'b1111, 15'h4000, 32'hDEAD_BEEF);

    // Byte loads at offset 3, signed then unsigned.
    load_tx("ld_b_s", 32'h1001_0003, 3'b000, 32'h80FF_0000, 4'b1000, 15'h4000, 32'hFFFF_FF80);
    load_tx("ld_b_u", 32'h1001_0003, 3'b100, 32'h80FF_0000, 4'b1000, 15'h4000, 32'h0000_0080);

    // Half loads: signed at offset 2, unsigned aligned, signed misaligned non-crossing.
    load_tx("ld_h_s", 32'h1001_0002, 3'b001, 32'h8001_1234, 4'b1100, 15'h4000, 32'hFFFF_8001);
    load_tx("ld_h_u", 32'h1001_0000, 3'b101, 32'h0000_F00D, 4'b0011, 15'h4000, 32'h0000_F00D);
    load_tx("ld_h_o1", 32'h1001_0001, 3'b001, 32'h00BE_EF00, 4'b0110, 15'h4000, 32'hFFFF_BEEF);

    // Top of the data range: last word and last byte are legal.
    load_tx("ld_w_end", 32'h1001_FFFC, 3'b010, 32'h89AB_CDEF, 4'b1111, 15'h7FFF, 32'h89AB_CDEF);
    load_tx("ld_b_end", 32'h1001_FFFF, 3'b000, 32'h7F00_0000, 4'b1000, 15'h7FFF, 32'h0000_007F);

    // Rejected accesses.
    err_tx("err_range", 1'b0, 3'b010, 32'h2000_0000);
    err_tx("err_fmt", 1'b0, 3'b011, 32'h1001_0000);
    err_tx("err_below", 1'b0, 3'b000, 32'h1000_FFFF);
    err_tx("err_tail", 1'b1, 3'b001, 32'h1001_FFFF);

`ifdef DMEM_MISALIGNED_SPLIT_EN
    // Word load crossing a word boundary: two beats.
    issue(1'b0, 3'b010, 32'h1001_0002, 32'h0);
    chk("split_ld.b0_valid", {31'b0, mem_valid}, 32'd1);
    chk("split_ld.b0_addr", {17'b0, mem_address}, 32'h4000);
    chk("split_ld.b0_be", {28'b0, mem_byteena}, 32'hC);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAABB_CCDD;
    step();
    mem_rvalid = 1'b0;
    chk("split_ld.b1_valid", {31'b0, mem_valid}, 32'd1);
    chk("split_ld.b1_addr", {17'b0, mem_address}, 32'h4001);
    chk("split_ld.b1_be", {28'b0, mem_byteena}, 32'h3);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1122_3344;
    step();
    mem_rvalid = 1'b0;
    chk("split_ld.resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("split_ld.rdata", resp_rdata, 32'h3344_AABB);
    step();

    // Half store crossing a word boundary.
    issue(1'b1, 3'b001, 32'h1001_0003, 32'h0000_1234);
    chk("split_st.b0_be", {28'b0, mem_byteena}, 32'h8);
    chk("split_st.b0_wdata", mem_wdata, 32'h3400_0000);
    step();
    chk("split_st.b1_be", {28'b0, mem_byteena}, 32'h1);
    chk("split_st.b1_wdata", mem_wdata, 32'h0000_0012);
    chk("split_st.b1_addr", {17'b0, mem_address}, 32'h4001);
    step();
    chk("split_st.resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("split_st.resp_error", {31'b0, resp_error}, 32'd0);
    step();
`else
    // Without splitting, word-crossing accesses are rejected.
    err_tx("nosplit_ld_w", 1'b0, 3'b010, 32'h1001_0002);
    err_tx("nosplit_st_h", 1'b1, 3'b001, 32'h1001_0003);
`endif

    // Stalled half store at offset 1: command must hold while mem_ready is low.
    mem_ready = 1'b0;
    issue(1'b1, 3'b001, 32'h1001_0001, 32'h0000_1234);
    chk("stall.be", {28'b0, mem_byteena}, 32'h6);
    chk("stall.wdata", mem_wdata, 32'h0012_3400);
    step();
    chk("stall.hold_valid", {31'b0, mem_valid}, 32'd1);
    chk("stall.hold_be", {28'b0, mem_byteena}, 32'h6);
    chk("stall.hold_wdata", mem_wdata, 32'h0012_3400);
    chk("stall.hold_addr", {17'b0, mem_address}, 32'h4000);
    chk("stall.no_resp", {31'b0, resp_valid}, 32'd0);
    mem_ready = 1'b1;
    step();
    chk("stall.resp_valid", {31'b0, resp_valid}, 32'd1);
    step();

    // Spurious read data while idle is ignored.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    chk("spurious.no_resp", {31'b0, resp_valid}, 32'd0);
    chk("spurious.ready", {31'b0, req_ready}, 32'd1);

    // Reset while waiting for read data, then a late mem_rvalid.
    issue(1'b0, 3'b010, 32'h1001_0004, 32'h0);
    step();
    chk("midrst.in_wait", {31'b0, req_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    step();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    chk("midrst.late_rvalid", {31'b0, resp_valid}, 32'd0);
    chk("midrst.ready", {31'b0, req_ready}, 32'd1);
    step();
    chk("midrst.still_idle", {31'b0, resp_valid}, 32'd0);
    load_tx("post_rst", 32'h1001_0001, 3'b100, 32'h0000_AB00, 4'b0010, 15'h4000, 32'h0000_00AB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
